latch_bank_param: RTL

//   Parametrised, clocked successor to the quad D-latch: GROUPS independent

---
 rtl/latch_bank_param.sv | 64 ++++++
 1 files changed

// File: rtl/latch_bank_param.sv
// Bank of independently enabled register groups with optional transparent output path
// and a per-group sticky "updated" flag cleared by an ack handshake.
module latch_bank_param #(
    parameter int unsigned        GROUPS      = 2,
    parameter int unsigned        GROUP_W     = 2,
    parameter bit                 TRANSPARENT = 1'b1,
    parameter logic [GROUP_W-1:0] RESET_VAL   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [GROUPS*GROUP_W-1:0] d,
    input  logic [GROUPS-1:0]         en,
    input  logic                      clr,
    input  logic [GROUPS-1:0]         ack,
    output logic [GROUPS*GROUP_W-1:0] q,
    output logic [GROUPS-1:0]         upd
);

    logic [GROUPS*GROUP_W-1:0] s_q, s_d;
    logic [GROUPS-1:0]         upd_q, upd_d;
    logic [GROUPS-1:0]         upd_set;

    always_comb begin
        s_d     = s_q;
        upd_d   = upd_q;
        upd_set = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            upd_set[g] = en[g] &&
                         (d[g*GROUP_W +: GROUP_W] != s_q[g*GROUP_W +: GROUP_W]);
            if (en[g]) begin
                s_d[g*GROUP_W +: GROUP_W] = d[g*GROUP_W +: GROUP_W];
            end
            // A fresh change beats a simultaneous ack so the change is never lost.
            if (upd_set[g]) begin
                upd_d[g] = 1'b1;
            end else if (ack[g]) begin
                upd_d[g] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s_q   <= {GROUPS{RESET_VAL}};
            upd_q <= '0;
        end else begin
            s_q   <= s_d;
            upd_q <= upd_d;
        end
    end

    for (genvar g = 0; g < GROUPS; g++) begin : gen_q
        if (TRANSPARENT) begin : gen_transparent
            assign q[g*GROUP_W +: GROUP_W] = (en[g] && rst_n && !clr) ?
                                             d[g*GROUP_W +: GROUP_W] :
                                             s_q[g*GROUP_W +: GROUP_W];
        end else begin : gen_registered
            assign q[g*GROUP_W +: GROUP_W] = s_q[g*GROUP_W +: GROUP_W];
        end
    end

    assign upd = upd_q;

endmodule
